// File: rtl/lbist_pkg.sv
// Shared LBIST definitions: sequencer state codes, default timing constants
// and a helper that sizes the run timer.
package lbist_pkg;

  localparam int TIMEOUT_DEFAULT = 4096;
  localparam int GAP_DEFAULT     = 8;
  localparam int RUN_W_DEFAULT   = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_GAP    = 3'd3;
  localparam logic [2:0] ST_REPORT = 3'd4;

  // The timer only ever needs to reach max(timeout, gap) - 1.
  function automatic int timer_width(input int timeout, input int gap);
    int m;
    m = (timeout > gap) ? timeout : gap;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/lbist_host_sequencer_if.sv
// Session control, LBIST handshake and statistics bundle of the host sequencer.
// The sequencer uses the master view, the system/LBIST environment the slave view.
interface lbist_host_sequencer_if
  import lbist_pkg::*;
#(
  parameter int RUN_W = RUN_W_DEFAULT
) ();

  logic             session_start;
  logic [RUN_W-1:0] num_runs;
  logic             abort;
  logic             test_done;
  logic             P_F;
  logic             test_start;
  logic             busy;
  logic             session_done;
  logic             session_pass;
  logic             aborted;
  logic [RUN_W-1:0] pass_cnt;
  logic [RUN_W-1:0] fail_cnt;
  logic [RUN_W-1:0] timeout_cnt;
  logic [RUN_W-1:0] first_fail_idx;

  modport master (
    input  session_start, num_runs, abort, test_done, P_F,
    output test_start, busy, session_done, session_pass, aborted,
           pass_cnt, fail_cnt, timeout_cnt, first_fail_idx
  );

  modport slave (
    output session_start, num_runs, abort, test_done, P_F,
    input  test_start, busy, session_done, session_pass, aborted,
           pass_cnt, fail_cnt, timeout_cnt, first_fail_idx
  );

endinterface

// File: rtl/lbist_run_timer.sv
// Clearable up-counter with a terminal-count flag; reused for the per-run
// timeout and for the inter-run gap.
module lbist_run_timer #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         Rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] tc_value_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == tc_value_i);

endmodule

// File: rtl/lbist_host_sequencer.sv
// LBIST initiator: runs a session of back-to-back self-tests with per-run
// timeout and inter-run gap, and reports pass/fail/timeout statistics.
module lbist_host_sequencer
  import lbist_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int GAP_CYCLES     = GAP_DEFAULT,
  parameter int RUN_W          = RUN_W_DEFAULT
) (
  input logic                   clk,
  input logic                   Rst,
  lbist_host_sequencer_if.master bus
);

  localparam int TW = timer_width(TIMEOUT_CYCLES, GAP_CYCLES);
  localparam logic [TW-1:0] TO_TC  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] GAP_TC = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  logic [2:0]       state_q, state_d;
  logic [RUN_W-1:0] runs_q, runs_d;
  logic [RUN_W-1:0] run_idx_q, run_idx_d;
  logic [RUN_W-1:0] pass_q, pass_d;
  logic [RUN_W-1:0] fail_q, fail_d;
  logic [RUN_W-1:0] tmo_q, tmo_d;
  logic [RUN_W-1:0] ffi_q, ffi_d;
  logic             aborted_q, aborted_d;
  logic             spass_q, spass_d;
  logic             done_q;

  logic tmr_tc, done_ev, timeout_ev;

  function automatic logic [RUN_W-1:0] sat_inc(input logic [RUN_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Any state change restarts the timer, so WAIT and GAP each count from zero.
  lbist_run_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .Rst        (Rst),
    .clr_i      (state_d != state_q),
    .en_i       ((state_q == ST_WAIT) || (state_q == ST_GAP)),
    .tc_value_i ((state_q == ST_GAP) ? GAP_TC : TO_TC),
    .tc_o       (tmr_tc)
  );

  assign done_ev    = (state_q == ST_WAIT) && bus.test_done && !done_q;
  assign timeout_ev = (state_q == ST_WAIT) && tmr_tc && !done_ev;

  always_comb begin
    state_d   = state_q;
    runs_d    = runs_q;
    run_idx_d = run_idx_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    tmo_d     = tmo_q;
    ffi_d     = ffi_q;
    aborted_d = aborted_q;
    spass_d   = spass_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.session_start) begin
          runs_d    = (bus.num_runs == '0) ? RUN_W'(1) : bus.num_runs;
          run_idx_d = '0;
          pass_d    = '0;
          fail_d    = '0;
          tmo_d     = '0;
          ffi_d     = '1;
          aborted_d = 1'b0;
          spass_d   = 1'b0;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (bus.abort) begin
          aborted_d = 1'b1;
          state_d   = ST_REPORT;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A done edge wins over a coincident timeout, and even over an abort.
        if (done_ev) begin
          if (bus.P_F) begin
            pass_d = sat_inc(pass_q);
          end else begin
            fail_d = sat_inc(fail_q);
            if (ffi_q == '1) ffi_d = run_idx_q;
          end
        end else if (timeout_ev && !bus.abort) begin
          tmo_d = sat_inc(tmo_q);
          if (ffi_q == '1) ffi_d = run_idx_q;
        end
        if (bus.abort) begin
          aborted_d = 1'b1;
          state_d   = ST_REPORT;
        end else if (done_ev || timeout_ev) begin
          if (run_idx_q == runs_q - 1'b1) begin
            state_d = ST_REPORT;
          end else begin
            run_idx_d = run_idx_q + 1'b1;
            state_d   = (GAP_CYCLES == 0) ? ST_START : ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (bus.abort) begin
          aborted_d = 1'b1;
          state_d   = ST_REPORT;
        end else if (tmr_tc) begin
          state_d = ST_START;
        end
      end
      ST_REPORT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    // Verdict is settled on entry to REPORT so it is valid alongside session_done.
    if ((state_d == ST_REPORT) && (state_q != ST_REPORT))
      spass_d = (fail_d == '0) && (tmo_d == '0) && !aborted_d;
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= ST_IDLE;
      runs_q    <= '0;
      run_idx_q <= '0;
      pass_q    <= '0;
      fail_q    <= '0;
      tmo_q     <= '0;
      ffi_q     <= '1;
      aborted_q <= 1'b0;
      spass_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      runs_q    <= runs_d;
      run_idx_q <= run_idx_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      tmo_q     <= tmo_d;
      ffi_q     <= ffi_d;
      aborted_q <= aborted_d;
      spass_q   <= spass_d;
      done_q    <= bus.test_done;
    end
  end

  assign bus.test_start     = (state_q == ST_START);
  assign bus.busy           = (state_q != ST_IDLE);
  assign bus.session_done   = (state_q == ST_REPORT);
  assign bus.session_pass   = spass_q;
  assign bus.aborted        = aborted_q;
  assign bus.pass_cnt       = pass_q;
  assign bus.fail_cnt       = fail_q;
  assign bus.timeout_cnt    = tmo_q;
  assign bus.first_fail_idx = ffi_q;

endmodule

// File: tb/tb_lbist_host_sequencer.sv
// Scoreboard bench for lbist_host_sequencer: a session-level reference model
// predicts test_start cycles and final statistics, a monitor compares them.
module tb_lbist_host_sequencer;
  import lbist_pkg::*;

  localparam int T = 16;
  localparam int G = 2;
  localparam int W = 8;

  typedef struct {
    int cyc;
    int pass;
    int fail;
    int tmo;
    int ffi;
    int ab;
    int sp;
  } exp_t;

  logic clk = 1'b0;
  logic Rst;
  int   cyc = 0;
  int   nChecks = 0;
  int   nPass = 0;

  int   startQ[$];
  exp_t resQ[$];
  int   dlyQ[$];
  bit   pfQ[$];
  int   planD[$];
  bit   planP[$];
  int   riseAt[$];
  bit   riseP[$];

  lbist_host_sequencer_if #(.RUN_W(W)) bus ();

  lbist_host_sequencer #(
    .TIMEOUT_CYCLES(T),
    .GAP_CYCLES    (G),
    .RUN_W         (W)
  ) dut (
    .clk(clk),
    .Rst(Rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual == expected) nPass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
  endtask

  // Delay 1..T means the core answers inside the window; 0 (none) or >T means a timeout.
  function automatic int effDelay(input int d);
    return (d >= 1 && d <= T) ? d : T;
  endfunction

  // Responder: each test_start consumes one planned (delay, verdict) and pulses test_done.
  always @(negedge clk) begin
    int d;
    bit p;
    bus.test_done = 1'b0;
    bus.P_F       = 1'($urandom_range(0, 1));
    for (int i = riseAt.size() - 1; i >= 0; i--) begin
      if (riseAt[i] <= cyc) begin
        if (riseAt[i] == cyc) begin
          bus.test_done = 1'b1;
          bus.P_F       = riseP[i];
        end
        riseAt.delete(i);
        riseP.delete(i);
      end
    end
    if (!Rst && bus.test_start && planD.size() > 0) begin
      d = planD.pop_front();
      p = planP.pop_front();
      if (d != 0) begin
        riseAt.push_back(cyc + d);
        riseP.push_back(p);
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents test_start or session_done.
  always @(negedge clk) begin
    int   e;
    exp_t x;
    if (!Rst) begin
      if (bus.test_start) begin
        if (startQ.size() == 0) begin
          checkOutput("unexpected test_start", cyc, -1);
        end else begin
          e = startQ.pop_front();
          checkOutput("test_start cycle", cyc, e);
        end
      end
      if (bus.session_done) begin
        if (resQ.size() == 0) begin
          checkOutput("unexpected session_done", cyc, -1);
        end else begin
          x = resQ.pop_front();
          checkOutput("session_done cycle", cyc, x.cyc);
          checkOutput("pass_cnt", int'(bus.pass_cnt), x.pass);
          checkOutput("fail_cnt", int'(bus.fail_cnt), x.fail);
          checkOutput("timeout_cnt", int'(bus.timeout_cnt), x.tmo);
          checkOutput("first_fail_idx", int'(bus.first_fail_idx), x.ffi);
          checkOutput("aborted", int'(bus.aborted), x.ab);
          checkOutput("session_pass", int'(bus.session_pass), x.sp);
        end
      end
    end
  end

  // Runs one session: predicts the outcome from dlyQ/pfQ, then drives start/abort/spurious start.
  task automatic applyStimulus(input int nRuns, input int abortRun, input int abortOff, input bit spur);
    int   a, r, s, doneC, absX, spAt, waitN, d, e;
    bit   resp;
    exp_t x;
    waitN = 0;
    @(negedge clk);
    while (bus.busy && waitN < 300) begin
      @(negedge clk);
      waitN++;
    end
    if (bus.busy) checkOutput("idle before session", 1, 0);
    a     = cyc;
    planD = dlyQ;
    planP = pfQ;
    r     = (nRuns == 0) ? 1 : nRuns;
    s     = a + 1;
    absX  = -1;
    doneC = -1;
    x     = '{cyc: 0, pass: 0, fail: 0, tmo: 0, ffi: 255, ab: 0, sp: 0};
    for (int k = 0; k < r; k++) begin
      d    = dlyQ[k];
      e    = effDelay(d);
      resp = (d >= 1 && d <= T);
      startQ.push_back(s);
      if (k == abortRun) absX = s + abortOff;
      if (k == abortRun && abortOff <= e) begin
        x.ab = 1;
        if (abortOff == e && resp) begin
          if (pfQ[k]) x.pass++;
          else begin
            x.fail++;
            if (x.ffi == 255) x.ffi = k;
          end
        end
        doneC = s + abortOff + 1;
        break;
      end
      if (resp && pfQ[k]) x.pass++;
      else begin
        if (resp) x.fail++;
        else x.tmo++;
        if (x.ffi == 255) x.ffi = k;
      end
      if (k == r - 1) begin
        doneC = s + e + 1;
        break;
      end
      if (k == abortRun) begin
        x.ab  = 1;
        doneC = s + abortOff + 1;
        break;
      end
      s = s + e + G + 1;
    end
    x.cyc = doneC;
    x.sp  = (x.fail == 0 && x.tmo == 0 && x.ab == 0) ? 1 : 0;
    resQ.push_back(x);
    bus.num_runs      = W'(nRuns);
    bus.session_start = 1'b1;
    spAt = spur ? a + 1 + int'($urandom_range(0, doneC - a - 1)) : -1;
    while (cyc < doneC + 25) begin
      @(negedge clk);
      bus.session_start = (cyc == spAt);
      if (cyc == spAt) bus.num_runs = W'($urandom_range(0, 255));
      bus.abort = (cyc == absX);
    end
    bus.abort         = 1'b0;
    bus.session_start = 1'b0;
    checkOutput("held pass_cnt", int'(bus.pass_cnt), x.pass);
    checkOutput("held session_pass", int'(bus.session_pass), x.sp);
    planD.delete();
    planP.delete();
  endtask

  initial begin
    int a, n, rr, d, abortRun, abortOff;
    Rst               = 1'b1;
    bus.session_start = 1'b0;
    bus.num_runs      = '0;
    bus.abort         = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset test_start", int'(bus.test_start), 0);
    checkOutput("reset busy", int'(bus.busy), 0);
    checkOutput("reset session_done", int'(bus.session_done), 0);
    checkOutput("reset session_pass", int'(bus.session_pass), 0);
    checkOutput("reset aborted", int'(bus.aborted), 0);
    checkOutput("reset pass_cnt", int'(bus.pass_cnt), 0);
    checkOutput("reset fail_cnt", int'(bus.fail_cnt), 0);
    checkOutput("reset timeout_cnt", int'(bus.timeout_cnt), 0);
    checkOutput("reset first_fail_idx", int'(bus.first_fail_idx), 255);
    Rst = 1'b0;
    repeat (2) @(negedge clk);

    dlyQ = '{10, 10, 10};        pfQ = '{1, 1, 1};
    applyStimulus(3, -1, 0, 0);
    dlyQ = '{10, 10, 10, 10};    pfQ = '{1, 0, 1, 1};
    applyStimulus(4, -1, 0, 0);
    dlyQ = '{T + 1, 5};          pfQ = '{1, 1};
    applyStimulus(2, -1, 0, 0);
    dlyQ = '{T};                 pfQ = '{1};
    applyStimulus(1, -1, 0, 0);
    dlyQ = '{4, 10, 10, 10, 10}; pfQ = '{1, 1, 1, 1, 1};
    applyStimulus(5, 1, 3, 1);
    dlyQ = '{6};                 pfQ = '{0};
    applyStimulus(0, -1, 0, 0);

    // Reset asserted mid-WAIT of run 1 after run 0 has passed.
    @(negedge clk);
    a     = cyc;
    dlyQ  = '{2, 12, 12};
    pfQ   = '{1, 1, 1};
    planD = dlyQ;
    planP = pfQ;
    startQ.push_back(a + 1);
    startQ.push_back(a + 6);
    bus.num_runs      = 8'd3;
    bus.session_start = 1'b1;
    @(negedge clk);
    bus.session_start = 1'b0;
    while (cyc < a + 8) @(negedge clk);
    checkOutput("pass_cnt before reset", int'(bus.pass_cnt), 1);
    #2 Rst = 1'b1;
    #1;
    checkOutput("async reset busy", int'(bus.busy), 0);
    checkOutput("async reset test_start", int'(bus.test_start), 0);
    checkOutput("async reset pass_cnt", int'(bus.pass_cnt), 0);
    checkOutput("async reset first_fail_idx", int'(bus.first_fail_idx), 255);
    repeat (2) @(negedge clk);
    Rst = 1'b0;
    planD.delete();
    planP.delete();
    riseAt.delete();
    riseP.delete();
    dlyQ = '{7, 9}; pfQ = '{1, 0};
    applyStimulus(2, -1, 0, 0);

    for (int t = 0; t < 30; t++) begin
      n  = int'($urandom_range(0, 4));
      rr = (n == 0) ? 1 : n;
      dlyQ.delete();
      pfQ.delete();
      for (int k = 0; k < rr; k++) begin
        case ($urandom_range(0, 7))
          0:       d = 0;
          1:       d = T;
          2:       d = T + 1 + int'($urandom_range(0, 1));
          default: d = int'($urandom_range(1, T - 1));
        endcase
        dlyQ.push_back(d);
        pfQ.push_back(1'($urandom_range(0, 1)));
      end
      abortRun = -1;
      abortOff = 0;
      if ($urandom_range(0, 3) == 0) begin
        abortRun = int'($urandom_range(0, rr - 1));
        d        = effDelay(dlyQ[abortRun]);
        abortOff = int'($urandom_range(0, (abortRun == rr - 1) ? d : d + G));
      end
      applyStimulus(n, abortRun, abortOff, 1'($urandom_range(0, 1)));
    end

    checkOutput("pending test_start expectations", startQ.size(), 0);
    checkOutput("pending session_done expectations", resQ.size(), 0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
